select_sequencer: RTL and testbench

Sequencer that drains vector-register lanes through the lane select unit, one 32-bit element at a time, into a scalar consumer. It drives the select unit's lane index, registers the selected element and hands it off over a valid/ready interface. It sits between the vector register file's select unit and the scalar core's vector-to-scalar move and reduction path.

---
 rtl/select_sequencer.sv | 155 +++++++++++++++
 tb/tb_select_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/select_sequencer.sv
// select_sequencer: drains vector-register lanes through the lane select unit,
// one 32-bit element per handshake, into a scalar consumer.
//
// Optional feature macro: SELSEQ_WRAP_EN
//   defined   -> lane index wraps modulo K; a request is legal when
//                first_lane < K and count <= K.
//   undefined -> no wrap logic; a request is legal when first_lane + count <= K
//                (evaluated at 33 bits so it cannot overflow).
//
// Output handshake: out_data_o is offered while out_valid_o is high and is
// consumed on a rising edge where out_valid_o and out_ready_i are both high.
// Once raised, out_valid_o stays high and out_data_o stays stable until that
// handshake; only abort_i or reset may drop it early.
module select_sequencer #(
  parameter int unsigned K = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] first_lane_i,
  input  logic [31:0] count_i,
  input  logic        abort_i,
  output logic [31:0] sel_index_o,
  input  logic [31:0] sel_data_i,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] index_q, index_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d;

  logic        req_legal;
  logic [31:0] index_inc;
  logic        slot_free;

`ifdef SELSEQ_WRAP_EN
  localparam logic [31:0] K32 = 32'(K);

  // Wrapping mode: any in-range start lane with at most K elements is legal.
  assign req_legal = (first_lane_i < K32) && (count_i <= K32);
  // Next lane wraps from K-1 back to lane 0.
  assign index_inc = (index_q == (K32 - 32'd1)) ? 32'd0 : (index_q + 32'd1);
`else
  localparam logic [32:0] K33 = 33'(K);
  logic [32:0] req_end;

  // Linear mode: the whole run must fit below K, summed at 33 bits.
  assign req_end   = {1'b0, first_lane_i} + {1'b0, count_i};
  assign req_legal = (req_end <= K33);
  assign index_inc = index_q + 32'd1;
`endif

  // The output register can take a new element when empty or being drained.
  assign slot_free = !out_valid_q || out_ready_i;

  // State and datapath registers; reset forces IDLE and clears all outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      index_q     <= 32'd0;
      remaining_q <= 32'd0;
      out_data_q  <= 32'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath logic; abort overrides everything but reset.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;

    if (abort_i) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (count_i == 32'd0) begin
              state_d = S_DONE;
            end else if (req_legal) begin
              index_d     = first_lane_i;
              remaining_d = count_i;
              state_d     = S_RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (slot_free) begin
            out_data_d  = sel_data_i;
            out_valid_d = 1'b1;
            remaining_d = remaining_q - 32'd1;
            // Park on the last lane so sel_index never leaves the legal range.
            if (remaining_q == 32'd1) begin
              state_d = S_DRAIN;
            end else begin
              index_d = index_inc;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready_i) begin
            out_valid_d = 1'b0;
            state_d     = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign sel_index_o = index_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_select_sequencer.sv
// Bench for select_sequencer: reference model builds the expected element list
// from first_lane/count/K, a scoreboard queue checks every handshake in order.
module tb_select_sequencer;

  localparam int unsigned K = 8;
`ifdef SELSEQ_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] first_lane;
  logic [31:0] count;
  logic        abort;
  logic [31:0] sel_index;
  logic [31:0] sel_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;

  logic [31:0] lane_mem [K];
  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  select_sequencer #(.K(K)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .first_lane_i (first_lane),
    .count_i      (count),
    .abort_i      (abort),
    .sel_index_o  (sel_index),
    .sel_data_i   (sel_data),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .dbg_state_o  (dbg_state)
  );

  // Behavioural select unit: out-of-range indices return a poison pattern.
  assign sel_data = (sel_index < K) ? lane_mem[sel_index[2:0]] : (32'hbad0_0000 | sel_index);

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One request: model the expected elements, drive it, score every handshake.
  task automatic do_req(input logic [31:0] first, input logic [31:0] cnt,
                        input int ready_pct, input int stall_at, input int stall_len,
                        input bit hold_start);
    longint      fl, ct;
    bit          legal, accepted, r, done_seen;
    bit          prev_valid, prev_hs;
    logic [31:0] prev_data, e;
    int          stalls, hs, stall_cnt, first_valid;
    fl = first; ct = cnt;
    legal = WRAP ? (fl < K && ct <= K) : (fl + ct <= K);
    accepted = (cnt == 0) || legal;
    exp_q.delete();
    if (legal)
      for (longint i = 0; i < ct; i++)
        exp_q.push_back(lane_mem[WRAP ? (fl + i) % K : fl + i]);
    stalls = 0; hs = 0; stall_cnt = 0; first_valid = -1;
    done_seen = 0; prev_valid = 0; prev_hs = 0; prev_data = '0;

    @(negedge clk);
    start = 1'b1; first_lane = first; count = cnt; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (!hold_start || !accepted) start = 1'b0;
      if (cyc == 1) begin
        check("busy_c1", busy, accepted);
        check("err_c1", err, !accepted);
        if (accepted && cnt != 0) check("sel_c1", sel_index, first);
      end
      if (!accepted) begin
        check("rej_no_valid", out_valid, 1'b0);
        check("rej_no_busy", busy, 1'b0);
        if (cyc == 2) check("err_pulse_end", err, 1'b0);
        if (cyc == 3) break;
        continue;
      end
      if (prev_valid && !prev_hs) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        check("first_valid_cyc", cyc, 2);
      end
      if (done) begin
        done_seen = 1;
        check("done_cyc", cyc, (cnt == 0) ? 1 : cnt + 2 + stalls);
        check("done_no_valid", out_valid, 1'b0);
        check("all_consumed", exp_q.size(), 0);
        start = 1'b0;
        break;
      end
      if (out_valid && hs == stall_at && stall_cnt < stall_len) begin
        r = 1'b0;
        stall_cnt++;
      end else begin
        r = ($urandom_range(0, 99) < ready_pct);
      end
      out_ready = r;
      if (out_valid) begin
        if (r) begin
          if (exp_q.size() == 0) begin
            check("extra_elem", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("elem", out_data, e);
          end
          hs++;
        end else begin
          stalls++;
        end
      end
      prev_valid = out_valid;
      prev_hs = out_valid && r;
      prev_data = out_data;
    end
    if (accepted) begin
      check("done_seen", done_seen, 1'b1);
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_valid", out_valid, 1'b0);
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  // Abort while the third element is presented and not accepted.
  task automatic do_abort();
    int hs;
    bit hit;
    hs = 0; hit = 0;
    @(negedge clk);
    start = 1'b1; first_lane = 32'd1; count = 32'd5; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        if (hs == 2) begin
          check("abort_elem", out_data, lane_mem[3]);
          out_ready = 1'b0;
          abort = 1'b1;
          hit = 1;
          break;
        end
        check("pre_abort_elem", out_data, lane_mem[1 + hs]);
        hs++;
      end
    end
    check("abort_reached", hit, 1'b1);
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", out_valid, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_err", err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_done", done, 1'b0);
      check("post_abort_valid", out_valid, 1'b0);
    end
  endtask

  // Asynchronous reset in the middle of a run.
  task automatic do_mid_reset();
    @(negedge clk);
    start = 1'b1; first_lane = 32'd0; count = K; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sel", sel_index, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_state", dbg_state, 2'd0);
  endtask

  // Main sequence: reset, directed cases, then randomized requests.
  initial begin
    logic [31:0] f, c;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; first_lane = '0; count = '0;
    abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < K; i++) lane_mem[i] = $urandom;
    repeat (2) @(negedge clk);
    check("reset_sel", sel_index, 32'd0);
    check("reset_data", out_data, 32'd0);
    check("reset_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(32'd2, 32'd4, 100, -1, 0, 1'b0);
    do_req(32'd2, 32'd4, 100, 1, 3, 1'b0);
    do_req(32'd6, 32'd4, 100, -1, 0, 1'b0);
    do_req(32'd3, 32'd0, 100, -1, 0, 1'b0);
    do_req(32'd1, 32'd3, 100, -1, 0, 1'b1);
    do_req(32'd0, K, 100, -1, 0, 1'b0);
    do_req(32'd7, 32'd1, 100, -1, 0, 1'b0);
    do_abort();
    do_req(32'd2, 32'd3, 100, -1, 0, 1'b0);
    do_mid_reset();
    do_req(32'd4, 32'd3, 70, -1, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      f = ($urandom_range(0, 9) == 0) ? K + $urandom_range(0, 3) : $urandom_range(0, K - 1);
      c = $urandom_range(0, K);
      if (f >= K && c == 0) c = 1;
      do_req(f, c, $urandom_range(40, 100), $urandom_range(0, K), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
